pim_mac_accum: RTL and testbench

PIM_MAC_ACCUM -- requirements
Module: pim_mac_accum

---
 rtl/pim_mac_accum.sv | 113 +++++++++++
 tb/tb_pim_mac_accum.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_mac_accum.sv
// Saturating signed accumulator for PIM MAC samples.
// A job sums cfg_len+1 samples, then presents the result on an AXI-Stream
// style output. The saturation flag travels with the result in tuser.
module pim_mac_accum #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] mac_in,
    input  logic                  mac_valid,
    output logic                  mac_ready,
    output logic [ACC_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   remaining;
    logic                   sat;

    logic                   accept;
    logic [ACC_WIDTH:0]     mac_ext;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   sum_clamped;
    logic                   sum_ovf;

    assign mac_ready = (state == ACCUM);
    assign accept    = mac_valid && mac_ready;

    // One guard bit above the accumulator makes overflow visible as a
    // disagreement between the two top bits of the sum.
    assign mac_ext = {{(ACC_WIDTH + 1 - DATA_WIDTH){mac_in[DATA_WIDTH-1]}}, mac_in};
    assign sum     = {acc[ACC_WIDTH-1], acc} + mac_ext;

    // Clamp the widened sum back into the signed accumulator range.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sum_clamped = sum[ACC_WIDTH-1:0];
        sum_ovf     = 1'b0;
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sum_ovf     = 1'b1;
            sum_clamped = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    // Job sequencing, accumulation and the sticky saturation flag.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= cfg_len;
                        acc       <= '0;
                        sat       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum_clamped;
                        if (sum_ovf) begin
                            sat <= 1'b1;
                        end
                        // The counter stops at zero: the sample taken at zero
                        // ends the job, so it never wraps.
                        if (remaining == '0) begin
                            state <= OUTPUT;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (m_axis_tready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers; tdata is the live accumulator.
    assign m_axis_tvalid = (state == OUTPUT);
    assign m_axis_tdata  = acc;
    assign m_axis_tuser  = sat;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_pim_mac_accum.sv
// Self-checking bench for pim_mac_accum. Two instances share all stimulus:
// the default 40-bit accumulator and a 36-bit one, so the saturation case can
// be exercised on the narrow build. Expected results go into per-instance
// queues; monitors pop and compare on every output handshake.
module tb_pim_mac_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_len;
    logic [31:0] mac_in;
    logic        mac_valid;
    logic        m_axis_tready;

    logic        mac_ready;
    logic [39:0] tdata;
    logic        tuser;
    logic        tvalid;
    logic        busy;

    logic        mac_ready36;
    logic [35:0] tdata36;
    logic        tuser36;
    logic        tvalid36;
    logic        busy36;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [39:0] data;
        logic        user;
    } exp_t;

    exp_t q40[$];
    exp_t q36[$];

    always #5 clk = ~clk;

    pim_mac_accum dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .mac_in       (mac_in),
        .mac_valid    (mac_valid),
        .mac_ready    (mac_ready),
        .m_axis_tdata (tdata),
        .m_axis_tuser (tuser),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy)
    );

    pim_mac_accum #(.ACC_WIDTH(36)) dut36 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .mac_in       (mac_in),
        .mac_valid    (mac_valid),
        .mac_ready    (mac_ready36),
        .m_axis_tdata (tdata36),
        .m_axis_tuser (tuser36),
        .m_axis_tvalid(tvalid36),
        .m_axis_tready(m_axis_tready),
        .busy         (busy36)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [39:0] d40, input logic u40,
                                 input logic [39:0] d36, input logic u36);
        exp_t e;
        e.data = d40; e.user = u40; q40.push_back(e);
        e.data = d36; e.user = u36; q36.push_back(e);
    endtask

    task automatic start_job(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic sample(input logic [31:0] v);
        mac_valid = 1'b1;
        mac_in    = v;
        tick();
        mac_valid = 1'b0;
    endtask

    // Monitor for the 40-bit instance.
    always @(negedge clk) begin : mon40
        exp_t e;
        if (!rst && tvalid && m_axis_tready) begin
            if (q40.size() == 0) begin
                check("acc40 unexpected output", {24'd0, tdata}, 64'hDEAD);
            end else begin
                e = q40.pop_front();
                check("acc40 tdata", {24'd0, tdata}, {24'd0, e.data});
                check("acc40 tuser", {63'd0, tuser}, {63'd0, e.user});
            end
        end
    end

    // Monitor for the 36-bit instance; its result is sign-extended to 40 bits.
    always @(negedge clk) begin : mon36
        exp_t e;
        if (!rst && tvalid36 && m_axis_tready) begin
            if (q36.size() == 0) begin
                check("acc36 unexpected output", {28'd0, tdata36}, 64'hDEAD);
            end else begin
                e = q36.pop_front();
                check("acc36 tdata", {24'd0, {4{tdata36[35]}}, tdata36}, {24'd0, e.data});
                check("acc36 tuser", {63'd0, tuser36}, {63'd0, e.user});
            end
        end
    end

    initial begin : watchdog
        #100_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst           = 1'b1;
        start         = 1'b0;
        cfg_len       = '0;
        mac_in        = '0;
        mac_valid     = 1'b0;
        m_axis_tready = 1'b0;

        // Reset state, during and just after reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset tvalid",    {63'd0, tvalid},    64'd0);
        check("reset mac_ready", {63'd0, mac_ready}, 64'd0);
        check("reset busy",      {63'd0, busy},      64'd0);
        check("reset tdata",     {24'd0, tdata},     64'd0);
        check("reset tuser",     {63'd0, tuser},     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post-reset tvalid", {63'd0, tvalid}, 64'd0);
        check("post-reset busy",   {63'd0, busy},   64'd0);
        @(posedge clk); #1;

        // Four back-to-back samples: 10 - 3 + 7 + 1 = 15.
        m_axis_tready = 1'b1;
        expect_result(40'd15, 1'b0, 40'd15, 1'b0);
        start_job(8'd3);
        @(negedge clk);
        check("accum mac_ready", {63'd0, mac_ready}, 64'd1);
        check("accum busy",      {63'd0, busy},      64'd1);
        @(posedge clk); #1;
        sample(32'd10);
        sample(-32'sd3);
        sample(32'd7);
        @(negedge clk);
        check("no early tvalid", {63'd0, tvalid}, 64'd0);
        @(posedge clk); #1;
        sample(32'd1);
        @(negedge clk);
        check("tvalid one cycle after last", {63'd0, tvalid}, 64'd1);
        tick();
        @(negedge clk);
        check("tvalid dropped after handshake", {63'd0, tvalid}, 64'd0);
        check("idle after handshake busy",      {63'd0, busy},   64'd0);
        @(posedge clk); #1;

        // Single-sample job with a negative value: sign extension to 40 bits.
        expect_result(40'hFF_FFFF_FFFB, 1'b0, 40'hFF_FFFF_FFFB, 1'b0);
        start_job(8'd0);
        sample(-32'sd5);
        @(negedge clk);
        check("single sample tdata", {24'd0, tdata}, 64'h00_0000_00FF_FFFF_FFFB);
        @(posedge clk); #1;
        tick();

        // Maximum length job of 256 x 0x7FFFFFFF = 0x7F_FFFF_FF00.
        // Fits in 40 bits; the 36-bit build clamps to 0x7_FFFF_FFFF.
        // cfg_len is changed mid-job and must have no effect.
        expect_result(40'h7F_FFFF_FF00, 1'b0, 40'h07_FFFF_FFFF, 1'b1);
        start_job(8'd255);
        for (int i = 0; i < 256; i++) begin
            if (i == 10) cfg_len = 8'd0;
            sample(32'h7FFF_FFFF);
        end
        @(negedge clk);
        check("max job tvalid", {63'd0, tvalid}, 64'd1);
        @(posedge clk); #1;
        tick();

        // Backpressure: result held for 5 cycles while start/mac_in wiggle.
        m_axis_tready = 1'b0;
        expect_result(40'd300, 1'b0, 40'd300, 1'b0);
        start_job(8'd1);
        sample(32'd100);
        sample(32'd200);
        for (int i = 0; i < 5; i++) begin
            start     = i[0];
            mac_valid = 1'b1;
            mac_in    = 32'(i * 1000 + 7);
            @(negedge clk);
            check("stall tvalid",    {63'd0, tvalid},    64'd1);
            check("stall tdata",     {24'd0, tdata},     64'd300);
            check("stall tuser",     {63'd0, tuser},     64'd0);
            check("stall mac_ready", {63'd0, mac_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mac_valid     = 1'b0;
        start         = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("after stall busy",   {63'd0, busy},   64'd0);
        check("after stall tvalid", {63'd0, tvalid}, 64'd0);
        @(posedge clk); #1;
        tick();
        @(negedge clk);
        check("no job without new start", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // Gapped input: only valid cycles count, 4 + 4 + 4 = 12.
        expect_result(40'd12, 1'b0, 40'd12, 1'b0);
        start_job(8'd2);
        begin
            logic        vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            logic [31:0] dpat [6] = '{32'd4, 32'd99, 32'd77, 32'd4, 32'd55, 32'd4};
            for (int i = 0; i < 6; i++) begin
                mac_valid = vpat[i];
                mac_in    = dpat[i];
                tick();
            end
            mac_valid = 1'b0;
        end
        @(negedge clk);
        check("gapped tvalid", {63'd0, tvalid}, 64'd1);
        @(posedge clk); #1;
        tick();

        // Reset mid-job discards the partial sum; next job has no residue.
        start_job(8'd3);
        sample(32'd50);
        sample(32'd60);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("abort busy",   {63'd0, busy},   64'd0);
        check("abort tvalid", {63'd0, tvalid}, 64'd0);
        check("abort tdata",  {24'd0, tdata},  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post-abort tvalid", {63'd0, tvalid}, 64'd0);
        @(posedge clk); #1;
        expect_result(40'd9, 1'b0, 40'd9, 1'b0);
        start_job(8'd0);
        sample(32'd9);
        repeat (3) tick();

        check("acc40 results outstanding", 64'(q40.size()), 64'd0);
        check("acc36 results outstanding", 64'(q36.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
